// File: rtl/play_stream_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : play_stream_engine
// Purpose  : SDRAM-to-audio playback engine. Fetches words from start_addr up
//            to (not including) end_addr, stepping by speed words per fetch,
//            through a small prefetch FIFO into a single registered audio
//            output with a valid/ready handshake.
// Ports    : i_clk, i_rst_n (async active-low)
//            control   : i_start, i_stop, i_pause, i_loop, i_start_addr,
//                        i_end_addr, i_speed, o_busy, o_done
//            SDRAM     : o_read, o_addr, i_readdata, i_sdram_finished
//            audio     : o_audio_valid, o_audio_data, i_audio_ready
// Config   : PLAY_LOOP_EN - when defined, an exhausted fetch with i_loop=1
//            restarts at start_addr instead of ending playback.
// Revision : 1.0 - initial release
// ============================================================================
module play_stream_engine #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int SPEED_W    = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_pause,
    input  logic              i_loop,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [SPEED_W-1:0] i_speed,
    output logic              o_read,
    output logic [ADDR_W-1:0] o_addr,
    input  logic [DATA_W-1:0] i_readdata,
    input  logic              i_sdram_finished,
    output logic              o_audio_valid,
    output logic [DATA_W-1:0] o_audio_data,
    input  logic              i_audio_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [ADDR_W-1:0]  r_start_addr;
    logic [ADDR_W-1:0]  r_end_addr;
    logic [ADDR_W-1:0]  r_step;
    logic [ADDR_W-1:0]  r_fetch_addr;
    logic               r_exhausted;
    logic               r_read;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;

    logic               w_rd_done;
    logic               w_end;
    logic               w_stop;
    logic               w_issue;
    logic               w_load;
    logic               w_push;
    logic [c_CNT_W:0]   w_occupancy;
    logic [ADDR_W:0]    w_sum;
    logic               w_wrap;
    logic [ADDR_W-1:0]  w_step_in;

    assign w_rd_done = r_read && i_sdram_finished;

    // Natural end: nothing left to fetch, buffered or in flight.
    assign w_end  = (r_state == S_RUN) && r_exhausted && (r_count == '0)
                    && !r_out_valid && !r_read;
    // A stop coinciding with the natural end is superseded by the end.
    assign w_stop = (r_state == S_RUN) && i_stop && !w_end;

    // The output register counts as a prefetch slot, so at most FIFO_DEPTH
    // words are ever held between SDRAM and the sink.
    assign w_occupancy = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_out_valid};

    assign w_issue = (r_state == S_RUN) && !i_stop && !r_read && !r_exhausted
                     && (w_occupancy < c_DEPTH);
    assign w_push  = (r_state == S_RUN) && !i_stop && w_rd_done;
    assign w_load  = (r_state == S_RUN) && !i_stop && (r_count != '0) && !i_pause
                     && (!r_out_valid || i_audio_ready);

    // Next fetch address is computed one bit wider so a carry out of the
    // address space ends the stream instead of wrapping to zero.
    assign w_sum  = {1'b0, r_fetch_addr} + {1'b0, r_step};
    assign w_wrap = w_sum[ADDR_W] || (w_sum[ADDR_W-1:0] >= r_end_addr);

    assign w_step_in = (i_speed == '0) ? ADDR_W'(1) : ADDR_W'(i_speed);

`ifndef PLAY_LOOP_EN
    logic w_unused_loop;
    assign w_unused_loop = ^{i_loop, r_start_addr};
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_end) begin
                    w_state_nxt = S_IDLE;
                end else if (i_stop) begin
                    w_state_nxt = (r_read && !i_sdram_finished) ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_rd_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch side: configuration, read request, fetch address
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start_addr <= '0;
            r_end_addr   <= '0;
            r_step       <= '0;
            r_fetch_addr <= '0;
            r_exhausted  <= 1'b0;
            r_read       <= 1'b0;
            r_addr       <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_start_addr <= i_start_addr;
                r_end_addr   <= i_end_addr;
                r_step       <= w_step_in;
                r_fetch_addr <= i_start_addr;
                r_exhausted  <= (i_end_addr <= i_start_addr);
            end

            // Request is held stable until the arbiter reports completion;
            // this also covers the DRAIN state after a stop.
            if (w_issue) begin
                r_read <= 1'b1;
                r_addr <= r_fetch_addr;
            end else if (w_rd_done) begin
                r_read <= 1'b0;
            end

            if (w_push) begin
                if (w_wrap) begin
`ifdef PLAY_LOOP_EN
                    if (i_loop) begin
                        r_fetch_addr <= r_start_addr;
                    end else begin
                        r_exhausted  <= 1'b1;
                    end
`else
                    r_exhausted <= 1'b1;
`endif
                end else begin
                    r_fetch_addr <= w_sum[ADDR_W-1:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefetch FIFO and output register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_stop) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_readdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Pause only gates new loads; a presented sample stays valid
            // until the sink takes it.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_mem[r_rd_ptr];
            end else if (r_out_valid && i_audio_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_read        = r_read;
    assign o_addr        = r_addr;
    assign o_audio_valid = r_out_valid;
    assign o_audio_data  = r_out_data;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = w_end;

endmodule
`default_nettype wire

// File: tb/tb_play_stream_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_play_stream_engine
// Purpose  : Directed self-checking bench for play_stream_engine with a
//            fixed-latency SDRAM responder and an audio sink monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_play_stream_engine;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int SW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          pause;
    logic          loop_en;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic [SW-1:0] speed;
    logic          o_read;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] readdata;
    logic          sdram_fin;
    logic          o_audio_valid;
    logic [DW-1:0] o_audio_data;
    logic          audio_ready;
    logic          o_busy;
    logic          o_done;

    play_stream_engine #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .SPEED_W    (SW)
    ) u_dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_stop           (stop),
        .i_pause          (pause),
        .i_loop           (loop_en),
        .i_start_addr     (start_addr),
        .i_end_addr       (end_addr),
        .i_speed          (speed),
        .o_read           (o_read),
        .o_addr           (o_addr),
        .i_readdata       (readdata),
        .i_sdram_finished (sdram_fin),
        .o_audio_valid    (o_audio_valid),
        .o_audio_data     (o_audio_data),
        .i_audio_ready    (audio_ready),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hA500_0000 | {9'd0, a};
    endfunction

    // SDRAM responder, sink monitor and done monitor, all on the falling edge.
    int            lat_cfg = 3;
    int            lat_cnt = 0;
    logic [AW-1:0] rd_q  [$];
    logic [DW-1:0] smp_q [$];
    int            done_cnt = 0;
    int            done_idle = 0;

    always @(negedge clk) begin
        if (sdram_fin) begin
            sdram_fin = 1'b0;
            lat_cnt   = 0;
        end else if (o_read) begin
            lat_cnt++;
            if (lat_cnt >= lat_cfg) begin
                sdram_fin = 1'b1;
                readdata  = mem_word(o_addr);
                rd_q.push_back(o_addr);
            end
        end
        if (o_audio_valid && audio_ready) smp_q.push_back(o_audio_data);
        if (o_done) begin
            done_cnt++;
            if (!o_busy) done_idle++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        smp_q.delete();
        done_cnt  = 0;
        done_idle = 0;
    endtask

    task automatic start_play(input logic [AW-1:0] s, input logic [AW-1:0] e,
                              input logic [SW-1:0] sp);
        start_addr = s;
        end_addr   = e;
        speed      = sp;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i = 0;
        while (o_busy && i < budget) begin
            tick(1);
            i++;
        end
        check({tag, " idle"}, o_busy, 0);
    endtask

    task automatic check_stream(input string tag, input logic [AW-1:0] first,
                                input int step, input int n);
        logic [AW-1:0] a;
        check({tag, " nreads"}, rd_q.size(), n);
        check({tag, " nsamples"}, smp_q.size(), n);
        for (int i = 0; i < n; i++) begin
            a = first + AW'(i * step);
            if (i < rd_q.size())  check($sformatf("%s read%0d", tag, i), rd_q[i], a);
            if (i < smp_q.size()) check($sformatf("%s smp%0d", tag, i), smp_q[i], mem_word(a));
        end
    endtask

    logic [DW-1:0] held;
    int            cnt;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        start_addr = '0; end_addr = '0; speed = '0; readdata = '0;
        sdram_fin = 1'b0; audio_ready = 1'b0;
        tick(3);
        check("rst read",  o_read, 0);
        check("rst addr",  o_addr, 0);
        check("rst valid", o_audio_valid, 0);
        check("rst data",  o_audio_data, 0);
        check("rst busy",  o_busy, 0);
        check("rst done",  o_done, 0);
        rst_n = 1'b1;
        tick(2);

        // T1: basic stream, read latency, single done.
        clear_logs();
        audio_ready = 1'b1;
        start_play(23'h10, 23'h14, 3'd1);
        check("t1 read lat1", o_read, 0);
        tick(1);
        check("t1 read lat2", o_read, 1);
        check("t1 addr0", o_addr, 23'h10);
        wait_idle("t1", 200);
        check_stream("t1", 23'h10, 1, 4);
        check("t1 done", done_cnt, 1);
        check("t1 busy at done", done_idle, 0);

        // T2: step of 3.
        clear_logs();
        start_play(23'h0, 23'd10, 3'd3);
        wait_idle("t2", 200);
        check_stream("t2", 23'h0, 3, 4);
        check("t2 done", done_cnt, 1);

        // T3: sink stalled, prefetch bounded, held sample stable.
        clear_logs();
        audio_ready = 1'b0;
        start_play(23'h100, 23'h10A, 3'd1);
        tick(10);
        held = o_audio_data;
        check("t3 valid early", o_audio_valid, 1);
        tick(40);
        check("t3 nreads stalled", rd_q.size(), 4);
        check("t3 read low", o_read, 0);
        check("t3 valid held", o_audio_valid, 1);
        check("t3 data stable", o_audio_data, held);
        check("t3 data value", o_audio_data, mem_word(23'h100));
        audio_ready = 1'b1;
        wait_idle("t3", 400);
        check_stream("t3", 23'h100, 1, 10);
        check("t3 done", done_cnt, 1);

        // T4: pause while a sample is pending.
        clear_logs();
        audio_ready = 1'b0;
        start_play(23'h200, 23'h208, 3'd1);
        cnt = 0;
        while (!o_audio_valid && cnt < 50) begin
            tick(1);
            cnt++;
        end
        check("t4 valid seen", o_audio_valid, 1);
        pause = 1'b1;
        tick(2);
        audio_ready = 1'b1;
        tick(1);
        check("t4 pending sample done", smp_q.size(), 1);
        check("t4 valid dropped", o_audio_valid, 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (o_audio_valid) cnt++;
            tick(1);
        end
        check("t4 no valid paused", cnt, 0);
        check("t4 nreads paused", rd_q.size(), 5);
        check("t4 read low", o_read, 0);
        pause = 1'b0;
        wait_idle("t4", 200);
        check_stream("t4", 23'h200, 1, 8);
        check("t4 done", done_cnt, 1);

        // T5: stop with a read outstanding -> DRAIN, then fresh replay.
        clear_logs();
        lat_cfg = 8;
        start_play(23'h300, 23'h310, 3'd1);
        tick(1);
        check("t5 read up", o_read, 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("t5 drain busy", o_busy, 1);
        check("t5 drain read", o_read, 1);
        check("t5 drain addr", o_addr, 23'h300);
        wait_idle("t5", 50);
        check("t5 no done", done_cnt, 0);
        check("t5 no samples", smp_q.size(), 0);
        check("t5 drained reads", rd_q.size(), 1);
        lat_cfg = 3;
        clear_logs();
        start_play(23'h300, 23'h302, 3'd1);
        wait_idle("t5 replay", 200);
        check_stream("t5 replay", 23'h300, 1, 2);
        check("t5 replay done", done_cnt, 1);

        // T6: empty range.
        clear_logs();
        start_play(23'd5, 23'd5, 3'd1);
        check("t6 done", o_done, 1);
        check("t6 read", o_read, 0);
        check("t6 busy", o_busy, 1);
        tick(1);
        check("t6 busy after", o_busy, 0);
        check("t6 done after", o_done, 0);
        check("t6 done count", done_cnt, 1);
        check("t6 nreads", rd_q.size(), 0);

        // T7: speed 0 behaves as 1.
        clear_logs();
        start_play(23'h20, 23'h22, 3'd0);
        wait_idle("t7", 200);
        check_stream("t7", 23'h20, 1, 2);

`ifdef PLAY_LOOP_EN
        // T8: looping playback until stop.
        clear_logs();
        loop_en = 1'b1;
        start_play(23'h0, 23'h2, 3'd1);
        tick(60);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        loop_en = 1'b0;
        wait_idle("t8", 50);
        check("t8 no done", done_cnt, 0);
        check("t8 enough reads", rd_q.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < rd_q.size()) check($sformatf("t8 read%0d", i), rd_q[i], AW'(i % 2));
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
